fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller: the consumer/driver end of the 8-bit program counter interface.
- Reads `pc_addr` and fetches opcode and optional operand bytes from program memory.
- Drives the PC's `en`/`pc_in`/`data` inputs to increment or load branch targets.
- Hands complete non-branch instructions to the decoder over a valid/ready handshake.

Parameters:
- `DATA_W`, 8, width of address, opcode and operand (PC is fixed 8-bit; only 8 supported).
- `HALT_OP`, 8'h7F, opcode that is issued and then parks the sequencer.

Ports:
- `clock`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `pc_addr`  in  8  current PC value
- `pc_en`  out  1  PC enable (to PC `en`)
- `pc_in`  out  1  PC load select (to PC `pc_in`); 1 = load `pc_data`
- `pc_data`  out  8  branch target (to PC `data`)
- `mem_rd`  out  1  program-memory read request
- `mem_addr`  out  8  read address; always equals `pc_addr`
- `mem_rdata`  in  8  read data, valid when `mem_valid`=1
- `mem_valid`  in  1  read-data strobe; ignored while `mem_rd`=0
- `flag_z`  in  1  zero flag from datapath
- `flag_c`  in  1  carry flag from datapath
- `ir`  out  8  latched opcode
- `operand`  out  8  latched second byte (0 for one-byte instructions)
- `instr_valid`  out  1  `ir`/`operand` hold an instruction for the decoder
- `instr_ready`  in  1  decoder accepts the instruction
- `halted`  out  1  sequencer parked after `HALT_OP`

Behaviour:
- Reset (`rst`=0, async): state=S_OP; `ir`=0; `operand`=0; `pc_en`=`pc_in`=`mem_rd`=`instr_valid`=`halted`=0; `pc_data`=0. Reset mid-fetch or mid-issue abandons the instruction; no PC pulse is generated.
- Encoding: `ir[7]`=1 means two-byte instruction. Branch classes on `ir[7:4]`:
  - 4'hC JMP: always taken.
  - 4'hD JZ: taken if `flag_z`.
  - 4'hE JC: taken if `flag_c`.
- `pc_en`, `pc_in` and `pc_data` are combinational (Mealy) from state and inputs, so the PC updates on the same edge the sequencer changes state.
- S_OP:
  - `mem_rd`=1.
  - On `mem_valid`=1: `ir`<=`mem_rdata`, `operand`<=0, `pc_en`=1 (increment).
  - Next state: S_ARG if `mem_rdata[7]`, else S_ISSUE.
  - Without `mem_valid`: hold; `mem_rd` stays 1; `pc_en`=0.
- S_ARG:
  - `mem_rd`=1; address is the already-incremented PC.
  - On `mem_valid`: `operand`<=`mem_rdata`, `pc_en`=1.
  - Next state: S_BR if `ir[7:4]` is C/D/E, else S_ISSUE.
- S_BR (exactly 1 cycle):
  - Flags sampled this cycle.
  - If taken: `pc_en`=1, `pc_in`=1, `pc_data`=`operand`.
  - Otherwise all PC controls 0.
  - Next state: S_OP. Branches are never presented to the decoder.
- S_ISSUE:
  - `instr_valid`=1; `ir`/`operand` stable.
  - When `instr_ready`=1: go to S_HALT if `ir`==`HALT_OP`, else S_OP.
  - `instr_valid` is held until accepted.
- S_HALT: `halted`=1; all other outputs idle; exit only via reset.
- `mem_valid` in S_BR/S_ISSUE/S_HALT is ignored.
- At most one `pc_en` pulse per cycle.
- PC wrap 8'hFF -> 8'h00 is handled by the PC. The sequencer fetches across the wrap without special casing.
- Throughput with zero-wait memory and `instr_ready`=1:
  - one-byte instruction: 2 cycles
  - two-byte non-branch: 3 cycles
  - branch: 3 cycles

Test Plan:
- Reset with `pc_addr`=0, memory[0]=8'h12, `mem_valid` always 1, `instr_ready`=1 -> `pc_en` pulses once, `instr_valid` next cycle with `ir`=8'h12, `operand`=0; next fetch from address 1.
- Memory[0..1]=8'hC0,8'h40 (JMP 0x40) -> two `pc_en` pulses, then one cycle `pc_en`=1/`pc_in`=1/`pc_data`=8'h40; `instr_valid` never asserted; next `mem_addr`=8'h40.
- JZ 0x20 with `flag_z`=0 then rerun with `flag_z`=1 -> not-taken: `pc_addr` ends at start+2; taken: `pc_addr`=8'h20.
- Memory wait states: `mem_valid` low 3 cycles in S_OP and 2 in S_ARG for 8'h85,8'hAA -> `mem_rd` held, no `pc_en` until `mem_valid`; `operand`=8'hAA; `pc_addr` advanced exactly 2.
- Decoder backpressure: `instr_ready`=0 for 4 cycles -> `instr_valid` and `ir` held constant, `mem_rd`=0, no PC change; `HALT_OP` accepted -> `halted`=1, no further `mem_rd` until reset.
- Assert `rst`=0 in S_ARG mid-wait -> immediate idle outputs, `ir`=0; after release, fetch restarts at address 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads opcode/operand bytes, steers the external PC, issues non-branch instructions.
// Zero-wait latency 2 cycles (one-byte) / 3 cycles (two-byte, branch); stalls on mem_valid=0, holds instr_valid until instr_ready.
module fetch_sequencer #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] HALT_OP = 8'h7F
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_addr,
  output logic              pc_en,
  output logic              pc_in,
  output logic [DATA_W-1:0] pc_data,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  input  logic              flag_z,
  input  logic              flag_c,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] operand,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_OP    = 3'd0,
    S_ARG   = 3'd1,
    S_BR    = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] ir_nxt;
  logic [DATA_W-1:0] operand_nxt;
  logic [3:0]        br_class;
  logic              is_branch;
  logic              br_taken;

  assign mem_addr = pc_addr;
  assign br_class = ir[DATA_W-1 -: 4];

  always_comb begin
    is_branch = 1'b0;
    br_taken  = 1'b0;
    case (br_class)
      4'hC: begin is_branch = 1'b1; br_taken = 1'b1;   end
      4'hD: begin is_branch = 1'b1; br_taken = flag_z; end
      4'hE: begin is_branch = 1'b1; br_taken = flag_c; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    ir_nxt      = ir;
    operand_nxt = operand;
    pc_en       = 1'b0;
    pc_in       = 1'b0;
    pc_data     = '0;
    mem_rd      = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;

    case (state)
      S_OP: begin
        mem_rd = 1'b1;
        if (mem_valid) begin
          ir_nxt      = mem_rdata;
          operand_nxt = '0;
          pc_en       = 1'b1;
          state_nxt   = mem_rdata[DATA_W-1] ? S_ARG : S_ISSUE;
        end
      end
      S_ARG: begin
        mem_rd = 1'b1;
        if (mem_valid) begin
          operand_nxt = mem_rdata;
          pc_en       = 1'b1;
          state_nxt   = is_branch ? S_BR : S_ISSUE;
        end
      end
      S_BR: begin
        if (br_taken) begin
          pc_en   = 1'b1;
          pc_in   = 1'b1;
          pc_data = operand;
        end
        state_nxt = S_OP;
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_nxt = (ir == HALT_OP) ? S_HALT : S_OP;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = S_OP;
      end
    endcase

    // Outputs are Mealy, so an asserted reset must force them idle immediately.
    if (!rst) begin
      pc_en       = 1'b0;
      pc_in       = 1'b0;
      pc_data     = '0;
      mem_rd      = 1'b0;
      instr_valid = 1'b0;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state   <= S_OP;
      ir      <= '0;
      operand <= '0;
    end else begin
      state   <= state_nxt;
      ir      <= ir_nxt;
      operand <= operand_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random programs checked against an instruction-level model.
module tb_fetch_sequencer;

  localparam logic [7:0] HALT = 8'h7F;

  logic       clock = 1'b0;
  logic       rst;
  logic [7:0] pc_addr;
  logic       pc_en;
  logic       pc_in;
  logic [7:0] pc_data;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_valid;
  logic       flag_z;
  logic       flag_c;
  logic [7:0] ir;
  logic [7:0] operand;
  logic       instr_valid;
  logic       instr_ready;
  logic       halted;

  logic [7:0] mem [256];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  fetch_sequencer #(.DATA_W(8), .HALT_OP(HALT)) dut (
    .clock       (clock),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .pc_en       (pc_en),
    .pc_in       (pc_in),
    .pc_data     (pc_data),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .ir          (ir),
    .operand     (operand),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted)
  );

  assign mem_rdata = mem[mem_addr];

  // The program counter the sequencer drives.
  always @(posedge clock or negedge rst) begin
    if (!rst) pc_addr <= 8'h00;
    else if (pc_en) pc_addr <= pc_in ? pc_data : pc_addr + 8'd1;
  end

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  // Leaves reset asserted at a falling edge; the caller releases it.
  task automatic do_reset();
    @(negedge clock);
    rst = 1'b0; mem_valid = 1'b0; instr_ready = 1'b0; flag_z = 1'b0; flag_c = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    clear_mem();
    do_reset();
    #1;
    n_cmp++;
    if ({pc_en, pc_in, mem_rd, instr_valid, halted} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {pc_en, pc_in, mem_rd, instr_valid, halted});
    end
    n_cmp++;
    if ({ir, operand, pc_data} !== 24'h0) begin
      n_fail++; $display("FAIL reset_regs: got %h want 000000", {ir, operand, pc_data});
    end
    @(negedge clock);
    rst = 1'b1; #1;
    n_cmp++;
    if ({mem_rd, mem_addr, pc_en} !== {1'b1, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL reset_release: got %h want %h", {mem_rd, mem_addr, pc_en}, {1'b1, 8'h00, 1'b0});
    end
  endtask

  task automatic test_single_byte();
    clear_mem(); mem[0] = 8'h12;
    do_reset();
    rst = 1'b1; mem_valid = 1'b1; instr_ready = 1'b1; #1;
    n_cmp++;
    if ({pc_en, pc_in, mem_rd, instr_valid} !== 4'b1010) begin
      n_fail++; $display("FAIL single_fetch: got %b want 1010", {pc_en, pc_in, mem_rd, instr_valid});
    end
    @(negedge clock); #1;
    n_cmp++;
    if ({instr_valid, ir, operand} !== {1'b1, 8'h12, 8'h00}) begin
      n_fail++; $display("FAIL single_issue: got %h want %h", {instr_valid, ir, operand}, {1'b1, 8'h12, 8'h00});
    end
    n_cmp++;
    if ({pc_en, mem_rd} !== 2'b00) begin
      n_fail++; $display("FAIL single_issue_idle: got %b want 00", {pc_en, mem_rd});
    end
    @(negedge clock); #1;
    n_cmp++;
    if ({mem_rd, mem_addr} !== {1'b1, 8'h01}) begin
      n_fail++; $display("FAIL single_next_addr: got %h want %h", {mem_rd, mem_addr}, {1'b1, 8'h01});
    end
  endtask

  task automatic test_jmp();
    clear_mem(); mem[0] = 8'hC0; mem[1] = 8'h40;
    do_reset();
    rst = 1'b1; mem_valid = 1'b1; instr_ready = 1'b1; #1;
    n_cmp++;
    if ({pc_en, pc_in, instr_valid} !== 3'b100) begin
      n_fail++; $display("FAIL jmp_op: got %b want 100", {pc_en, pc_in, instr_valid});
    end
    @(negedge clock); #1;
    n_cmp++;
    if ({pc_en, pc_in, instr_valid, mem_addr} !== {3'b100, 8'h01}) begin
      n_fail++; $display("FAIL jmp_arg: got %h want %h", {pc_en, pc_in, instr_valid, mem_addr}, {3'b100, 8'h01});
    end
    @(negedge clock); #1;
    n_cmp++;
    if ({pc_en, pc_in, pc_data, instr_valid, mem_rd} !== {2'b11, 8'h40, 2'b00}) begin
      n_fail++; $display("FAIL jmp_br: got %h want %h", {pc_en, pc_in, pc_data, instr_valid, mem_rd}, {2'b11, 8'h40, 2'b00});
    end
    @(negedge clock); #1;
    n_cmp++;
    if ({mem_rd, mem_addr, instr_valid} !== {1'b1, 8'h40, 1'b0}) begin
      n_fail++; $display("FAIL jmp_target: got %h want %h", {mem_rd, mem_addr, instr_valid}, {1'b1, 8'h40, 1'b0});
    end
  endtask

  task automatic test_jz();
    logic [7:0] want;
    for (int z = 0; z < 2; z++) begin
      clear_mem(); mem[0] = 8'hD0; mem[1] = 8'h20;
      do_reset();
      flag_z = (z == 1);
      rst = 1'b1; mem_valid = 1'b1; instr_ready = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      want = (z == 1) ? 8'h20 : 8'h02;
      n_cmp++;
      if ({pc_addr, instr_valid} !== {want, 1'b0}) begin
        n_fail++; $display("FAIL jz_flag%0d: got pc %h iv %b want pc %h iv 0", z, pc_addr, instr_valid, want);
      end
    end
  endtask

  task automatic test_wait_states();
    clear_mem(); mem[0] = 8'h85; mem[1] = 8'hAA;
    do_reset();
    rst = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b0; #1;
      n_cmp++;
      if ({mem_rd, pc_en, mem_addr} !== {2'b10, 8'h00}) begin
        n_fail++; $display("FAIL wait_op%0d: got %h want %h", i, {mem_rd, pc_en, mem_addr}, {2'b10, 8'h00});
      end
      @(negedge clock);
    end
    mem_valid = 1'b1; #1;
    n_cmp++;
    if (pc_en !== 1'b1) begin
      n_fail++; $display("FAIL wait_op_accept: got %b want 1", pc_en);
    end
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      mem_valid = 1'b0; #1;
      n_cmp++;
      if ({mem_rd, pc_en, mem_addr} !== {2'b10, 8'h01}) begin
        n_fail++; $display("FAIL wait_arg%0d: got %h want %h", i, {mem_rd, pc_en, mem_addr}, {2'b10, 8'h01});
      end
      @(negedge clock);
    end
    mem_valid = 1'b1; #1;
    n_cmp++;
    if (pc_en !== 1'b1) begin
      n_fail++; $display("FAIL wait_arg_accept: got %b want 1", pc_en);
    end
    @(negedge clock);
    mem_valid = 1'b0; #1;
    n_cmp++;
    if ({instr_valid, ir, operand, pc_addr} !== {1'b1, 8'h85, 8'hAA, 8'h02}) begin
      n_fail++; $display("FAIL wait_issue: got %h want %h", {instr_valid, ir, operand, pc_addr}, {1'b1, 8'h85, 8'hAA, 8'h02});
    end
  endtask

  task automatic test_backpressure_halt();
    clear_mem(); mem[0] = HALT;
    do_reset();
    rst = 1'b1; mem_valid = 1'b1; instr_ready = 1'b0; #1;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({instr_valid, ir, mem_rd, pc_en, pc_addr} !== {1'b1, HALT, 2'b00, 8'h01}) begin
        n_fail++; $display("FAIL bp_hold%0d: got %h want %h", i, {instr_valid, ir, mem_rd, pc_en, pc_addr}, {1'b1, HALT, 2'b00, 8'h01});
      end
      @(negedge clock);
    end
    instr_ready = 1'b1; #1;
    n_cmp++;
    if ({instr_valid, halted} !== 2'b10) begin
      n_fail++; $display("FAIL bp_accept: got %b want 10", {instr_valid, halted});
    end
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      instr_ready = 1'($urandom); mem_valid = 1'b1; #1;
      n_cmp++;
      if ({halted, mem_rd, pc_en, instr_valid, pc_addr} !== {4'b1000, 8'h01}) begin
        n_fail++; $display("FAIL halt_idle%0d: got %h want %h", i, {halted, mem_rd, pc_en, instr_valid, pc_addr}, {4'b1000, 8'h01});
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_arg();
    clear_mem(); mem[0] = 8'h90; mem[1] = 8'h55;
    do_reset();
    rst = 1'b1; mem_valid = 1'b1; instr_ready = 1'b1; #1;
    @(negedge clock);
    mem_valid = 1'b0; #1;
    n_cmp++;
    if ({mem_rd, mem_addr, ir} !== {1'b1, 8'h01, 8'h90}) begin
      n_fail++; $display("FAIL mid_arg_wait: got %h want %h", {mem_rd, mem_addr, ir}, {1'b1, 8'h01, 8'h90});
    end
    #1;
    rst = 1'b0; #1;
    n_cmp++;
    if ({pc_en, pc_in, mem_rd, instr_valid, halted, ir, operand} !== {5'b0, 16'h0}) begin
      n_fail++; $display("FAIL mid_reset_idle: got %h want 0", {pc_en, pc_in, mem_rd, instr_valid, halted, ir, operand});
    end
    @(negedge clock);
    @(negedge clock);
    rst = 1'b1; mem_valid = 1'b1; #1;
    n_cmp++;
    if ({mem_rd, pc_en, mem_addr} !== {2'b11, 8'h00}) begin
      n_fail++; $display("FAIL mid_reset_restart: got %h want %h", {mem_rd, pc_en, mem_addr}, {2'b11, 8'h00});
    end
  endtask

  // Random programs, executed by an instruction-level interpreter to get the expected issue stream.
  task automatic test_random(input int runs);
    logic [15:0] exp_q [$];
    int          exp_cyc [$];
    logic [7:0]  pc;
    logic [7:0]  op;
    logic [7:0]  arg;
    logic [3:0]  cls;
    logic        zf;
    logic        cf;
    bit          zero_wait;
    bit          exp_halt;
    bit          taken;
    int          steps;
    int          cyc;
    int          got;
    int          c;
    for (int r = 0; r < runs; r++) begin
      zero_wait = (r < 2);
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      if (r % 2 == 1) mem[$urandom_range(2, 255)] = HALT;
      zf = 1'($urandom);
      cf = 1'($urandom);

      exp_q.delete(); exp_cyc.delete();
      pc = 8'h00; steps = 0; cyc = 0; exp_halt = 1'b0;
      while (!exp_halt && steps < 300 && exp_q.size() < 40) begin
        op = mem[pc]; pc = pc + 8'd1; arg = 8'h00;
        if (op[7]) begin arg = mem[pc]; pc = pc + 8'd1; end
        steps++;
        cls = op[7:4];
        if (cls == 4'hC || cls == 4'hD || cls == 4'hE) begin
          cyc += 3;
          taken = (cls == 4'hC) || (cls == 4'hD && zf) || (cls == 4'hE && cf);
          if (taken) pc = arg;
        end else begin
          cyc += op[7] ? 3 : 2;
          exp_q.push_back({op, arg});
          exp_cyc.push_back(cyc);
          if (op == HALT) exp_halt = 1'b1;
        end
      end

      do_reset();
      flag_z = zf; flag_c = cf;
      rst = 1'b1;
      got = 0; c = 0;
      while (got < exp_q.size() && c < 6000) begin
        mem_valid   = zero_wait ? 1'b1 : ($urandom_range(0, 3) != 0);
        instr_ready = zero_wait ? 1'b1 : ($urandom_range(0, 2) != 0);
        #1;
        c++;
        if (instr_valid && instr_ready) begin
          n_cmp++;
          if ({ir, operand} !== exp_q[got]) begin
            n_fail++; $display("FAIL rand_issue r%0d #%0d: got %h want %h", r, got, {ir, operand}, exp_q[got]);
          end
          if (zero_wait) begin
            n_cmp++;
            if (c != exp_cyc[got]) begin
              n_fail++; $display("FAIL rand_timing r%0d #%0d: got cycle %0d want %0d", r, got, c, exp_cyc[got]);
            end
          end
          got++;
        end
        @(negedge clock);
      end
      n_cmp++;
      if (got != exp_q.size()) begin
        n_fail++; $display("FAIL rand_budget r%0d: got %0d issues want %0d", r, got, exp_q.size());
      end
      if (exp_halt) begin
        #1;
        n_cmp++;
        if ({halted, mem_rd} !== 2'b10) begin
          n_fail++; $display("FAIL rand_halt r%0d: got %b want 10", r, {halted, mem_rd});
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; mem_valid = 1'b0; instr_ready = 1'b0; flag_z = 1'b0; flag_c = 1'b0;
    test_reset();
    test_single_byte();
    test_jmp();
    test_jz();
    test_wait_states();
    test_backpressure_halt();
    test_reset_mid_arg();
    test_random(8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
